get_reg: RTL and testbench

- Register-name lookup for the RISC-V core.
- Maps an integer register index (x0..x31) to its ABI mnemonic, packed as ASCII for register-dump and trace printing.
- Sits beside the execute stage and register file; used only by debug/trace logic, never on the datapath.
- Registered, one-request-per-cycle, fixed 1-cycle latency.

---
 rtl/reg_abi_pkg.sv | 68 ++++++
 rtl/get_reg.sv | 78 +++++++
 tb/tb_get_reg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reg_abi_pkg.sv
// ABI register-name tables for the RISC-V debug/trace path.
// Names are packed ASCII, right-justified and zero-padded on the left:
// the last character always sits in [7:0], unused leading bytes are 8'h00.
package reg_abi_pkg;

   localparam int ABI_IDX_W  = 6;
   localparam int ABI_NAME_W = 32;
   localparam int NUM_REGS   = 32;
   localparam int LEN_W      = 3;

   typedef logic [ABI_NAME_W-1:0] reg_name_t;
   typedef logic [LEN_W-1:0]      reg_len_t;

   // Packed ABI mnemonic per integer register. x8 is always "s0", never "fp".
   localparam reg_name_t ABI_NAME [NUM_REGS] = '{
      32'h7A65726F,  // x0  "zero"
      32'h00007261,  // x1  "ra"
      32'h00007370,  // x2  "sp"
      32'h00006770,  // x3  "gp"
      32'h00007470,  // x4  "tp"
      32'h00007430,  // x5  "t0"
      32'h00007431,  // x6  "t1"
      32'h00007432,  // x7  "t2"
      32'h00007330,  // x8  "s0"
      32'h00007331,  // x9  "s1"
      32'h00006130,  // x10 "a0"
      32'h00006131,  // x11 "a1"
      32'h00006132,  // x12 "a2"
      32'h00006133,  // x13 "a3"
      32'h00006134,  // x14 "a4"
      32'h00006135,  // x15 "a5"
      32'h00006136,  // x16 "a6"
      32'h00006137,  // x17 "a7"
      32'h00007332,  // x18 "s2"
      32'h00007333,  // x19 "s3"
      32'h00007334,  // x20 "s4"
      32'h00007335,  // x21 "s5"
      32'h00007336,  // x22 "s6"
      32'h00007337,  // x23 "s7"
      32'h00007338,  // x24 "s8"
      32'h00007339,  // x25 "s9"
      32'h00733130,  // x26 "s10"
      32'h00733131,  // x27 "s11"
      32'h00007433,  // x28 "t3"
      32'h00007434,  // x29 "t4"
      32'h00007435,  // x30 "t5"
      32'h00007436   // x31 "t6"
   };

   // Number of valid characters in each name above.
   localparam reg_len_t ABI_LEN [NUM_REGS] = '{
      3'd4, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
      3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
      3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
      3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2
   };

   // Table lookup helper for printing code; returns zero for out-of-range indices.
   function automatic reg_name_t abi_name(input logic [ABI_IDX_W-1:0] idx);
      reg_name_t r;
      r = '0;
      if (idx < ABI_IDX_W'(NUM_REGS)) begin
         r = ABI_NAME[idx[4:0]];
      end
      return r;
   endfunction

endpackage

// File: rtl/get_reg.sv
// Register-index to ABI-name lookup for debug and trace printing.
// One combinational decode feeding one output register stage: fixed 1-cycle
// latency, a new request may be presented every cycle.
//
// Handshake: a request is taken on every rising edge where req_valid=1 (there
// is no ready; the block never stalls). name_valid is high for exactly the
// cycle after an accepted request. With req_valid=0 the name/name_len/idx_err
// registers hold their last values and name_valid is 0.
module get_reg
   import reg_abi_pkg::*;
#(
   parameter int IDX_W  = ABI_IDX_W,
   parameter int NAME_W = ABI_NAME_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [IDX_W-1:0]  req_idx,
   output logic              name_valid,
   output logic [NAME_W-1:0] name,
   output logic [2:0]        name_len,
   output logic              idx_err
);

   logic              in_range;
   logic [NAME_W-1:0] dec_name;
   logic [2:0]        dec_len;

   logic              name_valid_d, name_valid_q;
   logic [NAME_W-1:0] name_d,       name_q;
   logic [2:0]        name_len_d,   name_len_q;
   logic              idx_err_d,    idx_err_q;

   // Decode the requested index; out-of-range indices produce an empty name.
   always_comb begin
      in_range = (req_idx < IDX_W'(NUM_REGS));
      dec_name = '0;
      dec_len  = '0;
      if (in_range) begin
         dec_name = NAME_W'(ABI_NAME[req_idx[4:0]]);
         dec_len  = ABI_LEN[req_idx[4:0]];
      end
   end

   // Load the decoded result on a request, otherwise hold and drop the pulse.
   always_comb begin
      name_valid_d = req_valid;
      name_d       = name_q;
      name_len_d   = name_len_q;
      idx_err_d    = idx_err_q;
      if (req_valid) begin
         name_d     = dec_name;
         name_len_d = dec_len;
         idx_err_d  = ~in_range;
      end
   end

   // Output register stage; reset discards any request in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         name_valid_q <= 1'b0;
         name_q       <= '0;
         name_len_q   <= '0;
         idx_err_q    <= 1'b0;
      end else begin
         name_valid_q <= name_valid_d;
         name_q       <= name_d;
         name_len_q   <= name_len_d;
         idx_err_q    <= idx_err_d;
      end
   end

   assign name_valid = name_valid_q;
   assign name       = name_q;
   assign name_len   = name_len_q;
   assign idx_err    = idx_err_q;

endmodule

// File: tb/tb_get_reg.sv
// Directed bench for get_reg: reset, full index sweep, invalid indices,
// hold behaviour and reset arriving together with a request.
module tb_get_reg;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [5:0]  req_idx;
   logic        name_valid;
   logic [31:0] name;
   logic [2:0]  name_len;
   logic        idx_err;

   int n_vec;
   int n_err;

   get_reg dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_idx    (req_idx),
      .name_valid (name_valid),
      .name       (name),
      .name_len   (name_len),
      .idx_err    (idx_err)
   );

   // Clock: 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Hand-derived ASCII names, grouped by ABI register class.
   function automatic logic [31:0] exp_name(input int i);
      logic [31:0] r;
      r = 32'h0;
      if      (i == 0)             r = 32'h7A65726F;
      else if (i == 1)             r = 32'h00007261;
      else if (i == 2)             r = 32'h00007370;
      else if (i == 3)             r = 32'h00006770;
      else if (i == 4)             r = 32'h00007470;
      else if (i >= 5  && i <= 7)  r = 32'h00007430 + 32'(i - 5);
      else if (i >= 8  && i <= 9)  r = 32'h00007330 + 32'(i - 8);
      else if (i >= 10 && i <= 17) r = 32'h00006130 + 32'(i - 10);
      else if (i >= 18 && i <= 25) r = 32'h00007332 + 32'(i - 18);
      else if (i >= 26 && i <= 27) r = 32'h00733130 + 32'(i - 26);
      else if (i >= 28 && i <= 31) r = 32'h00007433 + 32'(i - 28);
      return r;
   endfunction

   function automatic logic [31:0] exp_len(input int i);
      logic [31:0] r;
      if (i == 0)                  r = 32'd4;
      else if (i == 26 || i == 27) r = 32'd3;
      else if (i <= 31)            r = 32'd2;
      else                         r = 32'd0;
      return r;
   endfunction

   task automatic check_result(input int i);
      check_eq($sformatf("valid[%0d]", i), {31'b0, name_valid}, 32'd1);
      check_eq($sformatf("name[%0d]", i),  name, exp_name(i));
      check_eq($sformatf("len[%0d]", i),   {29'b0, name_len}, exp_len(i));
      check_eq($sformatf("err[%0d]", i),   {31'b0, idx_err}, (i >= 32) ? 32'd1 : 32'd0);
   endtask

   // Drive a back-to-back request stream; each result is checked one cycle later.
   task automatic run_seq(input int seq[$]);
      int prev;
      prev = -1;
      foreach (seq[k]) begin
         @(negedge clk);
         if (prev >= 0) check_result(prev);
         req_valid = 1'b1;
         req_idx   = 6'(seq[k]);
         prev      = seq[k];
      end
      @(negedge clk);
      check_result(prev);
      req_valid = 1'b0;
   endtask

   initial begin
      int seq[$];
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_idx   = '0;

      // Reset state.
      #12;
      check_eq("rst_valid", {31'b0, name_valid}, 32'd0);
      check_eq("rst_name",  name, 32'd0);
      check_eq("rst_len",   {29'b0, name_len}, 32'd0);
      check_eq("rst_err",   {31'b0, idx_err}, 32'd0);

      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("idle_valid", {31'b0, name_valid}, 32'd0);
      end

      // Sweep all registers, then invalid indices and recovery.
      seq = {};
      for (int i = 0; i < 32; i++) seq.push_back(i);
      seq.push_back(32);
      seq.push_back(63);
      seq.push_back(2);
      run_seq(seq);

      // Hold: one request then idle cycles.
      seq = {10};
      run_seq(seq);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("hold_valid", {31'b0, name_valid}, 32'd0);
         check_eq("hold_name",  name, 32'h00006130);
         check_eq("hold_len",   {29'b0, name_len}, 32'd2);
         check_eq("hold_err",   {31'b0, idx_err}, 32'd0);
      end

      // Reset asserted between edges while a request is pending.
      @(negedge clk);
      req_valid = 1'b1;
      req_idx   = 6'd5;
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_name",  name, 32'd0);
      check_eq("async_len",   {29'b0, name_len}, 32'd0);
      check_eq("async_valid", {31'b0, name_valid}, 32'd0);
      @(negedge clk);
      check_eq("mid_valid", {31'b0, name_valid}, 32'd0);
      check_eq("mid_name",  name, 32'd0);
      req_valid = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      check_eq("post_valid", {31'b0, name_valid}, 32'd0);
      seq = {5};
      run_seq(seq);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
